// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light input conditioning slice.
// Contents:
//   db_state_e          debounce cell state (DB_STABLE, DB_PENDING)
//   CH_LEFT/RIGHT/HAZ   channel indices; they fix the bit order of the bounce vector
//   DEB_CYCLES_DEFAULT  default number of stable cycles before an output changes
package tail_light_pkg;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  localparam int unsigned CH_LEFT  = 0;
  localparam int unsigned CH_RIGHT = 1;
  localparam int unsigned CH_HAZ   = 2;

  localparam int unsigned DEB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/tail_light_input_cond_debounce_cell.sv
// One conditioning channel: a 2-FF synchronizer followed by a debounce counter
// and a sticky bounce flag.
// Parameters:
//   DEB_CYCLES  consecutive cycles s2 must differ from the output before it flips (1..65535)
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset
//   raw     in   raw asynchronous switch input
//   level   out  debounced, registered level
//   bounce  out  sticky flag, set when a pending change is abandoned; cleared only by reset
module tail_light_debounce_cell
  import tail_light_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic bounce
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntTerm = CntW'(DEB_CYCLES - 1);

  logic            s1_q;
  logic            s2_q;
  logic            out_q;
  logic [CntW-1:0] cnt_q;
  logic            bounce_q;
  db_state_e       state_q;

  // Plain flop-to-flop synchronizer; nothing may sit between s1 and s2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // The count starts on the first cycle s2 differs from out, so a clean change
  // reaches out DEB_CYCLES edges after it reaches s2. state_q remembers that a
  // count was in progress so an early return to out can be flagged as bounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= 1'b0;
      cnt_q    <= '0;
      bounce_q <= 1'b0;
      state_q  <= DB_STABLE;
    end else if (s2_q != out_q) begin
      if (cnt_q == CntTerm) begin
        out_q   <= s2_q;
        cnt_q   <= '0;
        state_q <= DB_STABLE;
      end else begin
        cnt_q   <= cnt_q + CntW'(1);
        state_q <= DB_PENDING;
      end
    end else begin
      cnt_q <= '0;
      if (state_q == DB_PENDING) begin
        bounce_q <= 1'b1;
      end
      state_q <= DB_STABLE;
    end
  end

  assign level  = out_q;
  assign bounce = bounce_q;

endmodule

// File: rtl/tail_light_input_cond.sv
// Input conditioning for the tail-light sequencer: synchronizes and debounces
// the left, right and hazard switches and reports sticky bounce activity.
// Optional feature macro: TAIL_LIGHT_HAZ_LATCH_EN
//   defined   -> hazard is a push-button; each debounced rise toggles a latch driving haz
//   undefined -> haz is the debounced hazard level
// Parameters:
//   DEB_CYCLES  stable cycles required before an output changes (1..65535)
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   left_raw   in   raw left-turn switch
//   right_raw  in   raw right-turn switch
//   haz_raw    in   raw hazard switch
//   left       out  debounced left request
//   right      out  debounced right request
//   haz        out  debounced (or latched) hazard request
//   bounce     out  sticky bounce flags {haz, right, left}
module tail_light_input_cond
  import tail_light_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       haz_raw,
  output logic       left,
  output logic       right,
  output logic       haz,
  output logic [2:0] bounce
);

  logic haz_deb;

  tail_light_debounce_cell #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_left (
    .clk    (clk),
    .reset  (reset),
    .raw    (left_raw),
    .level  (left),
    .bounce (bounce[CH_LEFT])
  );

  tail_light_debounce_cell #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_right (
    .clk    (clk),
    .reset  (reset),
    .raw    (right_raw),
    .level  (right),
    .bounce (bounce[CH_RIGHT])
  );

  tail_light_debounce_cell #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_haz (
    .clk    (clk),
    .reset  (reset),
    .raw    (haz_raw),
    .level  (haz_deb),
    .bounce (bounce[CH_HAZ])
  );

`ifdef TAIL_LIGHT_HAZ_LATCH_EN
  logic haz_deb_prev_q;
  logic haz_latch_q;

  // Toggle lands one cycle after the debounced rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      haz_deb_prev_q <= 1'b0;
      haz_latch_q    <= 1'b0;
    end else begin
      haz_deb_prev_q <= haz_deb;
      if (haz_deb && !haz_deb_prev_q) begin
        haz_latch_q <= ~haz_latch_q;
      end
    end
  end

  assign haz = haz_latch_q;
`else
  assign haz = haz_deb;
`endif

endmodule

// File: tb/tb_tail_light_input_cond.sv
// Self-checking bench for tail_light_input_cond with DEB_CYCLES=4. Outputs are
// compared every cycle against a reference model that keeps the full history of
// sampled raw inputs since the last reset and decides each output from windows
// over that history.
module tb_tail_light_input_cond;

  localparam int unsigned DEB  = 4;
  localparam int          HMAX = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic       left_raw;
  logic       right_raw;
  logic       haz_raw;
  logic       left;
  logic       right;
  logic       haz;
  logic [2:0] bounce;

  tail_light_input_cond #(
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .left_raw  (left_raw),
    .right_raw (right_raw),
    .haz_raw   (haz_raw),
    .left      (left),
    .right     (right),
    .haz       (haz),
    .bounce    (bounce)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int   k;                    // edges since reset release
  logic rawh [3][0:HMAX-1];   // raw value sampled at each edge
  logic out_m [3];
  logic bnc_m [3];
  logic latch_m;
  logic hd1, hd2;             // debounced hazard level after the last two edges

  // Value the debounce logic sees at edge e: raw sampled two edges earlier.
  function automatic logic d_at(int ch, int e);
    if (e >= 3) return rawh[ch][e-2];
    return 1'b0;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int ch = 0; ch < 3; ch++) begin
      out_m[ch] = 1'b0;
      bnc_m[ch] = 1'b0;
    end
    latch_m = 1'b0;
    hd1     = 1'b0;
    hd2     = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    bit flip;
    k++;
    if (k < HMAX) begin
      for (int ch = 0; ch < 3; ch++) rawh[ch][k] = raw[ch];
    end
    for (int ch = 0; ch < 3; ch++) begin
      // Output flips once the last DEB values seen all disagree with it.
      flip = 1'b1;
      for (int j = 0; j < int'(DEB); j++) begin
        if (k - j < 1 || d_at(ch, k - j) == out_m[ch]) flip = 1'b0;
      end
      // A disagreement that was not completed and has now gone away is bounce.
      if (k >= 2 && d_at(ch, k - 1) != out_m[ch] && d_at(ch, k) == out_m[ch])
        bnc_m[ch] = 1'b1;
      if (flip) out_m[ch] = ~out_m[ch];
    end
    if (hd1 && !hd2) latch_m = ~latch_m;
    hd2 = hd1;
    hd1 = out_m[2];
  endtask

  function automatic logic haz_exp();
`ifdef TAIL_LIGHT_HAZ_LATCH_EN
    return latch_m;
`else
    return out_m[2];
`endif
  endfunction

  task automatic compare_all(input string ctx);
    check({ctx, ".left"},   {3'b0, left},  {3'b0, out_m[0]});
    check({ctx, ".right"},  {3'b0, right}, {3'b0, out_m[1]});
    check({ctx, ".haz"},    {3'b0, haz},   {3'b0, haz_exp()});
    check({ctx, ".bounce"}, {1'b0, bounce}, {1'b0, bnc_m[2], bnc_m[1], bnc_m[0]});
  endtask

  // Drive inputs on the falling edge, advance the model on the rising edge,
  // compare 1 time unit later.
  task automatic step(input logic [2:0] raw, input string ctx);
    @(negedge clk);
    {haz_raw, right_raw, left_raw} = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    compare_all(ctx);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    {haz_raw, right_raw, left_raw} = 3'($urandom);
    model_reset();
    #1;
    compare_all("rst_async");
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      compare_all("rst_hold");
      @(negedge clk);
      {haz_raw, right_raw, left_raw} = 3'($urandom);
    end
    {haz_raw, right_raw, left_raw} = 3'b000;
    reset = 1'b0;
  endtask

  int unsigned hold [3];
  logic [2:0]  rnd_raw;

  initial begin
    reset = 1'b1;
    {haz_raw, right_raw, left_raw} = 3'($urandom);
    model_reset();
    #1;
    compare_all("por");
    do_reset(3);
    for (int i = 0; i < 6; i++) step(3'b000, "idle");

    // Clean press on left.
    for (int i = 0; i < 10; i++) step(3'b001, "clean");
    for (int i = 0; i < 8; i++) step(3'b000, "clean_rel");

    // Bounce on right: high 3, low 1, high held.
    for (int i = 0; i < 3; i++) step(3'b010, "bnc");
    step(3'b000, "bnc");
    for (int i = 0; i < 10; i++) step(3'b010, "bnc");
    for (int i = 0; i < 8; i++) step(3'b000, "bnc_rel");

    // Reset in the middle of a left count.
    do_reset(1);
    for (int i = 0; i < 3; i++) step(3'b001, "midrst");
    do_reset(2);
    for (int i = 0; i < 10; i++) step(3'b001, "midrst");

    // Simultaneous left and right.
    do_reset(1);
    for (int i = 0; i < 10; i++) step(3'b011, "simul");
    for (int i = 0; i < 8; i++) step(3'b000, "simul_rel");

    // Hazard press, release, press, release.
    do_reset(1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) step(3'b100, "haz_press");
      for (int i = 0; i < 10; i++) step(3'b000, "haz_rel");
    end

    // Random hold lengths, mixing glitches with long presses and occasional resets.
    do_reset(1);
    rnd_raw = 3'b000;
    for (int ch = 0; ch < 3; ch++) hold[ch] = $urandom_range(1, 10);
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (hold[ch] == 0) begin
          rnd_raw[ch] = ~rnd_raw[ch];
          hold[ch] = $urandom_range(1, 10);
        end
        hold[ch]--;
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
        rnd_raw = 3'b000;
      end
      step(rnd_raw, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tail_light_input_cond.md
# tail_light_input_cond

Input conditioning stage directly upstream of the tail-light sequencer FSM. It takes the raw, asynchronous, bouncing stalk and hazard switch signals (`left_raw`, `right_raw`, `haz_raw`) and brings them into the `clk` domain. It filters out contact bounce and drives clean, glitch-free, registered `left`, `right` and `haz` levels straight into the sequencer's inputs. It also reports per-input bounce activity for diagnostics.

## Interface
- `DEB_CYCLES`, default 16: consecutive stable cycles required before an output changes; legal range 1..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `left_raw`  in  1  raw left-turn switch; asynchronous; may bounce.
- `right_raw`  in  1  raw right-turn switch; asynchronous; may bounce.
- `haz_raw`  in  1  raw hazard switch; asynchronous; may bounce.
- `left`  out  1  debounced left request to the sequencer.
- `right`  out  1  debounced right request to the sequencer.
- `haz`  out  1  debounced (or latched, see Configuration) hazard request to the sequencer.
- `bounce`  out  3  sticky bounce flags `{haz,right,left}`; cleared only by `reset`.

## Operation
- Each raw input gets a 2-FF synchronizer (`s1` feeds `s2`). No logic sits between the flops.
- Each channel has one debounce cell with a state register `out`, a counter `cnt`, and two states:
  - **STABLE** (`s2 == out`): `cnt` is held at 0.
  - **PENDING** (`s2 != out`): `cnt` increments each cycle.
- Transitions out of PENDING:
  - If `s2` returns to equal `out` before the count completes: go back to STABLE, `cnt` ← 0, and set this channel's `bounce` bit.
  - When `cnt == DEB_CYCLES-1` and `s2 != out` still holds: `out` ← `s2`, `cnt` ← 0, go to STABLE.
- Counter width is `$clog2(DEB_CYCLES+1)`. The counter never wraps, because it resets at terminal count.
- `left` and `right` are passed through independently. When both are asserted, both are output high; the sequencer treats that combination as hazard. No priority logic lives in this block.
- All outputs are registered. No combinational path exists from any input to any output.
- Reset values: `left`, `right`, `haz` = 0; `bounce` = 3'b000; all synchronizer flops, `out` and `cnt` = 0.
- Reset asserted mid-count: everything returns to reset values immediately (asynchronously). The partial count is discarded.

## Timing
- A clean raw transition that is sampled at edge 1 appears on the output at edge `DEB_CYCLES+2`.
  - 2 cycles of synchronizer delay.
  - `DEB_CYCLES` cycles of counting.
- With `DEB_CYCLES=1`, the output follows `s2` with 1 extra cycle, for a total latency of 3.
- A pulse or glitch shorter than `DEB_CYCLES` cycles at `s2` never reaches the output.
- A glitch ending exactly on the terminal-count edge, where `s2` equals `out` at that edge, does not toggle the output.
- The three channels are fully independent. Simultaneous transitions on several inputs resolve in the same cycle.

## Configuration
- Macro: `TAIL_LIGHT_HAZ_LATCH_EN`.
- Defined:
  - Hazard becomes a momentary push-button.
  - Each rising edge of the debounced hazard level toggles a latch register, and `haz` outputs that latch.
  - The toggle is applied one cycle after the debounced rise, so latency is `DEB_CYCLES+3`.
  - `reset` clears the latch.
- Undefined:
  - `haz` is the debounced hazard level itself, with latency `DEB_CYCLES+2`.
  - No latch or edge-detect logic is generated.

## Structure
- Shared package `tail_light_pkg` holds:
  - The debounce state enum (`DB_STABLE`, `DB_PENDING`).
  - The channel index constants (`CH_LEFT=0`, `CH_RIGHT=1`, `CH_HAZ=2`), which fix the bit order of `bounce`.
  - `DEB_CYCLES_DEFAULT`.
- Sub-module `tail_light_debounce_cell` contains one synchronizer, the counter and the bounce flag. It is instantiated three times. The top level adds the optional hazard latch.

## Test plan
All scenarios use `DEB_CYCLES=4`.
- Reset state: assert `reset` with random raw inputs → all outputs 0; after release with all raw inputs 0, outputs stay 0.
- Clean press: `left_raw` 0→1 before edge 1, then held → `left` rises exactly at edge 6; `bounce[0]` stays 0.
- Bounce rejection: `right_raw` high for 3 cycles, low for 1, then high and held → `right` rises 6 edges after the final rise; `bounce[1]` = 1; no early pulse on `right`.
- Reset mid-count: `left_raw` held high, `reset` pulsed at edge 4 → `left` stays 0 and rises at edge 6 counted from the first edge after reset release.
- Simultaneous inputs: `left_raw` and `right_raw` rise in the same cycle → `left` and `right` both rise at edge 6, in the same cycle.
- Hazard, both builds: press `haz_raw` for 10 cycles, release, press again.
  - With `TAIL_LIGHT_HAZ_LATCH_EN`: `haz` goes 1 at edge 7 and stays high until the second press toggles it to 0.
  - Without the macro: `haz` follows each press, delayed by 6 edges.
